// File: rtl/park_pkg.sv
// Shared types for the parking lot monitor: lane FSM states, {A,B} sensor codes
// and a small popcount helper used to total per-lane pulses.
package park_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } lane_state_t;

  // Sensor codes written as {A,B}; A is the outer beam, B the inner beam.
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_IN   = 2'b01;
  localparam logic [1:0] AB_OUT  = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/car_lane_fsm.sv
// One lane's A/B beam sequencer. A full 10,11,01,00 walk emits a one-cycle
// enter pulse; the mirrored 01,11,10,00 walk emits an exit pulse.
module car_lane_fsm
  import park_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  input  logic b,
  output logic enter_p,
  output logic exit_p
);

  lane_state_t r_state;
  lane_state_t w_state_next;
  logic        r_enter_p;
  logic        r_exit_p;
  logic        w_enter_next;
  logic        w_exit_next;
  logic [1:0]  w_ab;

  assign w_ab = {a, b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_enter_p <= 1'b0;
      r_exit_p  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_enter_p <= w_enter_next;
      r_exit_p  <= w_exit_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_enter_next = 1'b0;
    w_exit_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ab == AB_OUT)     w_state_next = EN1;
        else if (w_ab == AB_IN) w_state_next = EX1;
      end
      EN1: begin
        if (w_ab == AB_BOTH)     w_state_next = EN2;
        else if (w_ab != AB_OUT) w_state_next = IDLE;
      end
      EN2: begin
        if (w_ab == AB_IN)        w_state_next = EN3;
        else if (w_ab == AB_OUT)  w_state_next = EN1;
        else if (w_ab == AB_NONE) w_state_next = IDLE;
      end
      EN3: begin
        if (w_ab == AB_BOTH)     w_state_next = EN2;
        else if (w_ab == AB_OUT) w_state_next = IDLE;
        else if (w_ab == AB_NONE) begin
          w_state_next = IDLE;
          w_enter_next = 1'b1;
        end
      end
      EX1: begin
        if (w_ab == AB_BOTH)    w_state_next = EX2;
        else if (w_ab != AB_IN) w_state_next = IDLE;
      end
      EX2: begin
        if (w_ab == AB_OUT)       w_state_next = EX3;
        else if (w_ab == AB_IN)   w_state_next = EX1;
        else if (w_ab == AB_NONE) w_state_next = IDLE;
      end
      EX3: begin
        if (w_ab == AB_BOTH)    w_state_next = EX2;
        else if (w_ab == AB_IN) w_state_next = IDLE;
        else if (w_ab == AB_NONE) begin
          w_state_next = IDLE;
          w_exit_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign enter_p = r_enter_p;
  assign exit_p  = r_exit_p;

endmodule

// File: rtl/parking_lot_monitor.sv
// Multi-lane parking occupancy counter with saturating, sticky-flagged arithmetic.
// Define PARK_SENSOR_SYNC_EN to pass A/B through two-flop synchronisers first.
module parking_lot_monitor
  import park_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int CAPACITY  = 100,
  localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] A,
  input  logic [NUM_LANES-1:0] B,
  input  logic                 err_clr,
  output logic [NUM_LANES-1:0] car_enter,
  output logic [NUM_LANES-1:0] car_exit,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 lot_full,
  output logic                 lot_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int SW = CNT_W + 6;

  logic [NUM_LANES-1:0] w_a;
  logic [NUM_LANES-1:0] w_b;

`ifdef PARK_SENSOR_SYNC_EN
  logic [NUM_LANES-1:0] r_a_meta, r_a_sync;
  logic [NUM_LANES-1:0] r_b_meta, r_b_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_meta <= '0;
      r_a_sync <= '0;
      r_b_meta <= '0;
      r_b_sync <= '0;
    end else begin
      r_a_meta <= A;
      r_a_sync <= r_a_meta;
      r_b_meta <= B;
      r_b_sync <= r_b_meta;
    end
  end

  assign w_a = r_a_sync;
  assign w_b = r_b_sync;
`else
  assign w_a = A;
  assign w_b = B;
`endif

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    car_lane_fsm u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (w_a[gi]),
      .b       (w_b[gi]),
      .enter_p (car_enter[gi]),
      .exit_p  (car_exit[gi])
    );
  end

  logic [CNT_W-1:0]     r_occupancy;
  logic                 r_overflow_err;
  logic                 r_underflow_err;
  logic signed [SW-1:0] w_net;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_cap;
  logic [CNT_W-1:0]     w_occ_next;
  logic                 w_ovf_hit;
  logic                 w_udf_hit;

  // Widened signed math so neither a burst of entries nor exits can wrap.
  assign w_net = $signed(SW'(popcount16(16'(car_enter))))
               - $signed(SW'(popcount16(16'(car_exit))));
  assign w_sum = $signed(SW'(r_occupancy)) + w_net;
  assign w_cap = SW'(CAPACITY);

  always_comb begin
    w_ovf_hit  = 1'b0;
    w_udf_hit  = 1'b0;
    w_occ_next = w_sum[CNT_W-1:0];
    if (w_sum[SW-1]) begin
      w_udf_hit  = 1'b1;
      w_occ_next = '0;
    end else if (w_sum > w_cap) begin
      w_ovf_hit  = 1'b1;
      w_occ_next = CNT_W'(CAPACITY);
    end
  end

  // A saturation in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occupancy     <= '0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_occupancy <= w_occ_next;
      if (w_ovf_hit)    r_overflow_err <= 1'b1;
      else if (err_clr) r_overflow_err <= 1'b0;
      if (w_udf_hit)    r_underflow_err <= 1'b1;
      else if (err_clr) r_underflow_err <= 1'b0;
    end
  end

  assign occupancy     = r_occupancy;
  assign lot_full      = (r_occupancy == CNT_W'(CAPACITY));
  assign lot_empty     = (r_occupancy == '0);
  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_parking_lot_monitor.sv
// Directed table-driven bench for parking_lot_monitor (NUM_LANES=4, CAPACITY=3).
module tb_parking_lot_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       err_clr;
  logic [3:0] car_enter;
  logic [3:0] car_exit;
  logic [1:0] occupancy;
  logic       lot_full;
  logic       lot_empty;
  logic       overflow_err;
  logic       underflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  parking_lot_monitor #(.NUM_LANES(4), .CAPACITY(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .A             (A),
    .B             (B),
    .err_clr       (err_clr),
    .car_enter     (car_enter),
    .car_exit      (car_exit),
    .occupancy     (occupancy),
    .lot_full      (lot_full),
    .lot_empty     (lot_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       clr;
    logic [3:0] en;
    logic [3:0] ex;
    logic [1:0] occ;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic clr,
                              input logic [3:0] en, input logic [3:0] ex, input logic [1:0] occ,
                              input logic ovf, input logic udf);
    vec_t v;
    v.a = a; v.b = b; v.clr = clr; v.en = en; v.ex = ex; v.occ = occ; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".enter"}, 16'(car_enter), 16'h0);
    check({tag, ".exit"},  16'(car_exit),  16'h0);
    check({tag, ".occ"},   16'(occupancy), 16'h0);
    check({tag, ".full"},  16'(lot_full),  16'h0);
    check({tag, ".empty"}, 16'(lot_empty), 16'h1);
    check({tag, ".ovf"},   16'(overflow_err),  16'h0);
    check({tag, ".udf"},   16'(underflow_err), 16'h0);
  endtask

  // Drive one row, clock it, then compare what the edge produced.
  task automatic apply_vec(input vec_t v, input string tag);
    A = v.a; B = v.b; err_clr = v.clr;
    @(posedge clk);
    #1;
    $display("%s A=%b B=%b clr=%b -> enter=%b exit=%b occ=%0d full=%b empty=%b ovf=%b udf=%b",
             tag, v.a, v.b, v.clr, car_enter, car_exit, occupancy, lot_full, lot_empty,
             overflow_err, underflow_err);
    check({tag, ".enter"}, 16'(car_enter), 16'(v.en));
    check({tag, ".exit"},  16'(car_exit),  16'(v.ex));
    check({tag, ".occ"},   16'(occupancy), 16'(v.occ));
    check({tag, ".full"},  16'(lot_full),  16'(v.occ == 2'd3));
    check({tag, ".empty"}, 16'(lot_empty), 16'(v.occ == 2'd0));
    check({tag, ".ovf"},   16'(overflow_err),  16'(v.ovf));
    check({tag, ".udf"},   16'(underflow_err), 16'(v.udf));
  endtask

  initial begin
    reset_n = 1'b0; A = '0; B = '0; err_clr = 1'b0;

    //                 A      B    clr  enter  exit  occ ovf udf
    // lane0 entry
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h1, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h1, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h1, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0));
    // lane1 exit
    vecs.push_back(mk(4'h0, 4'h2, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(4'h2, 4'h2, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(4'h2, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h2, 1, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    // lane2 abort, then back-off
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h4, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h4, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    // lanes 0,1 enter together -> 2
    vecs.push_back(mk(4'h3, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h3, 4'h3, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h3, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h3, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 2, 0, 0));
    // lanes 0,1,2 enter together from 2 -> clip at 3, overflow; then err_clr
    vecs.push_back(mk(4'h7, 4'h0, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h7, 4'h7, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h7, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h7, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 3, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 3, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 3, 0, 0));
    // lane3 exit -> 2
    vecs.push_back(mk(4'h0, 4'h8, 0, 4'h0, 4'h0, 3, 0, 0));
    vecs.push_back(mk(4'h8, 4'h8, 0, 4'h0, 4'h0, 3, 0, 0));
    vecs.push_back(mk(4'h8, 4'h0, 0, 4'h0, 4'h0, 3, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h8, 3, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 2, 0, 0));
    // lane0 entry and lane3 exit cancel
    vecs.push_back(mk(4'h1, 4'h8, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h9, 4'h9, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h8, 4'h1, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h1, 4'h8, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 2, 0, 0));
    // lanes 0,1 exit together -> 0
    vecs.push_back(mk(4'h0, 4'h3, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h3, 4'h3, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h3, 4'h0, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h3, 2, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    // lane3 exit at 0 -> underflow
    vecs.push_back(mk(4'h0, 4'h8, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h8, 4'h8, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h8, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h8, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 1));
    // another underflow coinciding with err_clr keeps the flag, next err_clr drops it
    vecs.push_back(mk(4'h0, 4'h8, 0, 4'h0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(4'h8, 4'h8, 0, 4'h0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(4'h8, 4'h0, 0, 4'h0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'h8, 0, 0, 1));
    vecs.push_back(mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0));

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while lane0 sits in EN2, with occupancy at 1 beforehand
    apply_vec(mk(4'h2, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0), "r0");
    apply_vec(mk(4'h2, 4'h2, 0, 4'h0, 4'h0, 0, 0, 0), "r1");
    apply_vec(mk(4'h0, 4'h2, 0, 4'h0, 4'h0, 0, 0, 0), "r2");
    apply_vec(mk(4'h0, 4'h0, 0, 4'h2, 4'h0, 0, 0, 0), "r3");
    apply_vec(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0), "r4");
    apply_vec(mk(4'h1, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0), "r5");
    apply_vec(mk(4'h1, 4'h1, 0, 4'h0, 4'h0, 1, 0, 0), "r6");
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle: occ=%0d empty=%b", occupancy, lot_empty);
    check_reset_state("rst_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    apply_vec(mk(4'h0, 4'h1, 0, 4'h0, 4'h0, 0, 0, 0), "r7");
    apply_vec(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0), "r8");
    apply_vec(mk(4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0), "r9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
